// File: rtl/procedural_pkg.sv
// Shared types and constants for the procedural result frame accumulator.
// Imported by the term unit, the interface and the accumulator top.
package procedural_pkg;

  localparam int FRAME_LEN_DEFAULT = 8;
  localparam int ACC_W_DEFAULT     = 20;
  localparam int RES_W             = 16;
  localparam int TERM_W            = RES_W + 1;
  localparam int CNT_W             = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/procedural_frame_acc_if.sv
// Beat input and frame result handshake bundle for procedural_frame_acc.
// The master drives the beats and the result acceptance; the slave is the accumulator.
interface procedural_frame_acc_if
  import procedural_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] res1;
  logic [RES_W-1:0] res2;
  logic             res_sel;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] frame_sum;
  logic [CNT_W-1:0] sel_cnt;

  modport master (
    output in_valid,
    output res1,
    output res2,
    output res_sel,
    output clear,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  frame_sum,
    input  sel_cnt
  );

  modport slave (
    input  in_valid,
    input  res1,
    input  res2,
    input  res_sel,
    input  clear,
    input  out_ready,
    output in_ready,
    output out_valid,
    output frame_sum,
    output sel_cnt
  );

endinterface

// File: rtl/procedural_term.sv
// Combinational per-beat term: XOR of the two results when sel is set,
// otherwise their full-width 17-bit sum.
module procedural_term
  import procedural_pkg::*;
(
  input  logic [RES_W-1:0]  res1,
  input  logic [RES_W-1:0]  res2,
  input  logic              res_sel,
  output logic [TERM_W-1:0] term
);

  // Select between the XOR and carry-preserving sum forms of the beat.
  always_comb begin
    term = {TERM_W{1'b0}};
    if (res_sel) begin
      term = {1'b0, res1 ^ res2};
    end else begin
      term = {1'b0, res1} + {1'b0, res2};
    end
  end

endmodule

// File: rtl/procedural_frame_acc.sv
// Accumulates FRAME_LEN accepted beat terms into one frame result and holds it
// until downstream takes it; clear aborts the frame from any state.
module procedural_frame_acc
  import procedural_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int ACC_W     = ACC_W_DEFAULT
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  procedural_frame_acc_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic [TERM_W-1:0] term_s;
  logic [ACC_W-1:0]  term_ext_s;
  logic [CNT_W-1:0]  sel_inc_s;
  logic              accept_s;

  state_e            state_r;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  sel_cnt_r;
  logic              in_ready_r;
  logic              out_valid_r;

  procedural_term u_term (
    .res1    (bus.res1),
    .res2    (bus.res2),
    .res_sel (bus.res_sel),
    .term    (term_s)
  );

  assign term_ext_s = ACC_W'(term_s);
  assign sel_inc_s  = {{(CNT_W-1){1'b0}}, bus.res_sel};
  // in_ready_r is zero exactly in HOLD and under reset, so HOLD beats are ignored.
  assign accept_s   = bus.in_valid & in_ready_r;

  // Frame FSM with accumulator, counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sel_cnt_r   <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (bus.clear) begin
      state_r     <= ST_IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sel_cnt_r   <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          if (accept_s) begin
            acc_r     <= term_ext_s;
            cnt_r     <= {{(CNT_W-1){1'b0}}, 1'b1};
            sel_cnt_r <= sel_inc_s;
            state_r   <= ST_ACCUM;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_r     <= acc_r + term_ext_s;
            cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            sel_cnt_r <= sel_cnt_r + sel_inc_s;
            if (cnt_r == LAST_CNT) begin
              state_r     <= ST_HOLD;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= ST_ACCUM;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
            end
          end else begin
            state_r     <= ST_ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sel_cnt_r   <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= ST_HOLD;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          acc_r       <= {ACC_W{1'b0}};
          cnt_r       <= {CNT_W{1'b0}};
          sel_cnt_r   <= {CNT_W{1'b0}};
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.frame_sum = acc_r;
  assign bus.sel_cnt   = sel_cnt_r;

endmodule

// File: tb/tb_procedural_frame_acc.sv
// Directed self-checking bench for procedural_frame_acc (FRAME_LEN=8, ACC_W=20).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_procedural_frame_acc;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  procedural_frame_acc_if #(.ACC_W(20)) bus ();

  procedural_frame_acc #(.FRAME_LEN(8), .ACC_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_frame(input logic [15:0] a, input logic [15:0] b, input logic s, input int n);
    bus.in_valid = 1'b1;
    bus.res1     = a;
    bus.res2     = b;
    bus.res_sel  = s;
    repeat (n) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic consume;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.res1 = 16'h0; bus.res2 = 16'h0; bus.res_sel = 1'b0;
    bus.clear = 1'b0; bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.frame_sum !== 20'h0) begin errors++; $display("FAIL reset_frame_sum got %h want 0", bus.frame_sum); end
    checks++; if (bus.sel_cnt !== 5'd0) begin errors++; $display("FAIL reset_sel_cnt got %0d want 0", bus.sel_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_small_sum;
    drive_frame(16'h0001, 16'h0002, 1'b0, 7);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL small_early_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.frame_sum !== 20'd21) begin errors++; $display("FAIL small_running got %0d want 21", bus.frame_sum); end
    drive_frame(16'h0001, 16'h0002, 1'b0, 1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL small_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL small_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.frame_sum !== 20'd24) begin errors++; $display("FAIL small_sum got %0d want 24", bus.frame_sum); end
    checks++; if (bus.sel_cnt !== 5'd0) begin errors++; $display("FAIL small_sel_cnt got %0d want 0", bus.sel_cnt); end
    consume();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL small_consumed got %b want 0", bus.out_valid); end
    checks++; if (bus.frame_sum !== 20'd0) begin errors++; $display("FAIL small_zeroed got %0d want 0", bus.frame_sum); end
  endtask

  task automatic test_no_overflow;
    drive_frame(16'hFFFF, 16'hFFFF, 1'b0, 8);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.frame_sum !== 20'hFFFF0) begin errors++; $display("FAIL ovf_sum got %h want FFFF0", bus.frame_sum); end
    consume();
  endtask

  task automatic test_alternating;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        bus.res1 = 16'hF0F0; bus.res2 = 16'h0F0F; bus.res_sel = 1'b1;
      end else begin
        bus.res1 = 16'h0001; bus.res2 = 16'h0001; bus.res_sel = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL alt_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.frame_sum !== 20'h40004) begin errors++; $display("FAIL alt_sum got %h want 40004", bus.frame_sum); end
    checks++; if (bus.sel_cnt !== 5'd4) begin errors++; $display("FAIL alt_sel_cnt got %0d want 4", bus.sel_cnt); end
    consume();
  endtask

  task automatic test_hold_stall;
    drive_frame(16'h0001, 16'h0001, 1'b1, 8);
    bus.in_valid = 1'b1; bus.res1 = 16'h0003; bus.res2 = 16'h0004; bus.res_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_hs cycle %0d got v=%b r=%b want v=1 r=0", i, bus.out_valid, bus.in_ready); end
      checks++; if (bus.frame_sum !== 20'd0 || bus.sel_cnt !== 5'd8) begin errors++; $display("FAIL stall_hold cycle %0d got sum=%0d sel=%0d want sum=0 sel=8", i, bus.frame_sum, bus.sel_cnt); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.frame_sum !== 20'd0) begin errors++; $display("FAIL stall_release_sum got %0d want 0", bus.frame_sum); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.frame_sum !== 20'd7) begin errors++; $display("FAIL back_to_back_sum got %0d want 7", bus.frame_sum); end
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    checks++; if (bus.frame_sum !== 20'd0) begin errors++; $display("FAIL stall_clear_sum got %0d want 0", bus.frame_sum); end
  endtask

  task automatic test_clear;
    drive_frame(16'h0001, 16'h0002, 1'b1, 3);
    checks++; if (bus.frame_sum !== 20'd9 || bus.sel_cnt !== 5'd3) begin errors++; $display("FAIL clear_pre got sum=%0d sel=%0d want sum=9 sel=3", bus.frame_sum, bus.sel_cnt); end
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.res1 = 16'h0010; bus.res2 = 16'h0000; bus.res_sel = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.frame_sum !== 20'd0 || bus.sel_cnt !== 5'd0) begin errors++; $display("FAIL clear_zero got sum=%0d sel=%0d want 0 0", bus.frame_sum, bus.sel_cnt); end
    drive_frame(16'h0005, 16'h0000, 1'b0, 7);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clear_count got %b want 0", bus.out_valid); end
    drive_frame(16'h0005, 16'h0000, 1'b0, 1);
    checks++; if (bus.out_valid !== 1'b1 || bus.frame_sum !== 20'd40) begin errors++; $display("FAIL clear_new_frame got v=%b sum=%0d want v=1 sum=40", bus.out_valid, bus.frame_sum); end
    bus.clear = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.frame_sum !== 20'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_hold got v=%b sum=%0d r=%b want 0 0 1", bus.out_valid, bus.frame_sum, bus.in_ready); end
  endtask

  task automatic test_reset_in_hold;
    drive_frame(16'h0002, 16'h0002, 1'b0, 8);
    checks++; if (bus.out_valid !== 1'b1 || bus.frame_sum !== 20'd32) begin errors++; $display("FAIL rst_hold_pre got v=%b sum=%0d want v=1 sum=32", bus.out_valid, bus.frame_sum); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.frame_sum !== 20'd0) begin errors++; $display("FAIL rst_hold_async got v=%b sum=%0d want 0 0", bus.out_valid, bus.frame_sum); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_in_ready got %b want 0", bus.in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_recover got r=%b v=%b want 1 0", bus.in_ready, bus.out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_small_sum();
    test_no_overflow();
    test_alternating();
    test_hold_stall();
    test_clear();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/procedural_frame_acc.md
PROCEDURAL_FRAME_ACC -- requirements
Module: procedural_frame_acc

Interface
REQ-001 Parameter FRAME_LEN, default 8, SHALL set the number of accepted result beats per frame (legal range 2..16).
REQ-002 Parameter ACC_W, default 20, SHALL set the accumulator width; ACC_W SHALL be at least 17 + clog2(FRAME_LEN).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that res1/res2/res_sel carry a valid upstream result.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a beat this cycle.
REQ-007 res1  input  16  SHALL carry the upstream procedural result out1.
REQ-008 res2  input  16  SHALL carry the upstream procedural result out2.
REQ-009 res_sel  input  1  SHALL carry the sel value that produced res1/res2.
REQ-010 clear  input  1  SHALL be a synchronous frame abort.
REQ-011 out_valid  output  1  SHALL flag a completed frame on frame_sum/sel_cnt.
REQ-012 out_ready  input  1  SHALL be the downstream acceptance for the frame result.
REQ-013 frame_sum  output  ACC_W  SHALL carry the frame accumulation.
REQ-014 sel_cnt  output  5  SHALL carry the number of beats in the frame with res_sel=1.

Function
REQ-015 A beat SHALL be accepted exactly when in_valid and in_ready are both 1 at a rising edge.
REQ-016 Per beat term: res_sel=1 -> zero-extended (res1 ^ res2), 17 bits; res_sel=0 -> res1 + res2, 17-bit unsigned, no truncation.
REQ-017 The accumulator SHALL add each accepted term, unsigned, wrapping modulo 2^ACC_W.
REQ-018 FSM states: IDLE, ACCUM, HOLD.
REQ-019 IDLE: in_ready=1; an accepted beat loads acc=term and beat count=1, then moves to ACCUM.
REQ-020 ACCUM: in_ready=1; each accepted beat adds its term and increments the count.
REQ-021 When the beat that makes count = FRAME_LEN is accepted, the FSM SHALL move to HOLD.
REQ-022 HOLD: out_valid=1 and in_ready=0; frame_sum and sel_cnt SHALL remain stable.
REQ-023 Latency: out_valid SHALL assert on the cycle after the final beat is accepted.
REQ-024 HOLD with out_ready=1: the result is consumed and the FSM returns to IDLE with acc, count and sel_cnt zeroed; a back-to-back beat is accepted from the following cycle.
REQ-025 clear=1: from any state, the FSM SHALL go to IDLE and zero acc, count and sel_cnt on the next edge.
REQ-026 clear has priority over beat acceptance and over out_ready in the same cycle; the frame is discarded and out_valid deasserts.
REQ-027 in_valid in HOLD SHALL be ignored; upstream holds its data, which the source supplies combinationally.
REQ-028 frame_sum and sel_cnt are defined only while out_valid=1; otherwise they SHALL show the running values.

Reset
REQ-029 rst_n low SHALL asynchronously force: FSM=IDLE, acc=0, count=0, sel_cnt=0, out_valid=0, frame_sum=0.
REQ-030 in_ready SHALL be 0 while rst_n is low and 1 from the first edge after deassertion.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending frame without emitting out_valid.

Structure
REQ-032 Package procedural_pkg SHALL hold the FSM state enum, FRAME_LEN_DEFAULT, ACC_W_DEFAULT and RES_W=16.
REQ-033 Beat-term computation (REQ-016) SHALL be the sub-module procedural_term, purely combinational.
REQ-034 All other logic SHALL reside in procedural_frame_acc, with one sequential process using async reset.

Verification
REQ-035 Scenario: 8 beats of res1=0x0001, res2=0x0002, sel=0 -> out_valid one cycle after the 8th beat, frame_sum=24, sel_cnt=0.
REQ-036 Scenario: 8 beats of res1=0xFFFF, res2=0xFFFF, sel=0 -> frame_sum=8*0x1FFFE=0xFFFF0, no overflow.
REQ-037 Scenario: alternating sel=1 (0xF0F0^0x0F0F) and sel=0 (0x0001+0x0001), 8 beats -> frame_sum=4*0xFFFF+4*2=0x40004, sel_cnt=4.
REQ-038 Scenario: out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable, no beat accepted; out_ready=1 -> IDLE next cycle.
REQ-039 Scenario: clear with in_valid=1 after 3 beats -> beat not accepted, next frame sums only new beats.
REQ-040 Scenario: rst_n pulsed low in HOLD -> out_valid=0 immediately (asynchronous), frame_sum=0.
